nand_result_serializer: RTL
===========================

# nand_result_serializer

Downstream capture stage for the 4-bit NAND datapath. It accepts each 4-bit result word on a valid/ready handshake and buffers it in a small FIFO. It then transmits each word on a single-wire serial output as a start bit, the data bits LSB first, and a stop bit. This lets a bench or a pin-limited consumer observe NAND results without a parallel bus.

## Interface
- WIDTH, 4, result word width in bits; must be ≥1.
- DEPTH, 4, FIFO depth in words; must be a power of 2 and ≥2.

- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- in_valid  input  1  upstream holds a result word on in_data.
- in_data  input  WIDTH  result word, the NAND gate's Y.
- in_ready  output  1  FIFO can accept a word this cycle.
- ser_out  output  1  serial line; idles high.
- ser_busy  output  1  high while a frame is on the line (START, DATA or STOP).
- frame_done  output  1  one-cycle pulse during each frame's stop bit.
- fifo_count  output  log2(DEPTH)+1  number of words currently buffered.

## Operation
- Push: on a clk edge with in_valid && in_ready, write in_data at the write pointer and increment the pointer modulo DEPTH.
- in_ready = (fifo_count != DEPTH). It is combinational from the registered count.
- Upstream must hold in_data stable while in_valid && !in_ready. No data is ever dropped.
- Pop: load the head word into the shift register and increment the read pointer modulo DEPTH.
- fifo_count changes by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
- The FIFO has no bypass. A word pushed into an empty FIFO is popped no earlier than the following edge.
- FSM states are IDLE, START, DATA and STOP, with a bit counter 0..WIDTH-1.
  - IDLE: ser_out=1. If fifo_count≠0, pop and go to START.
  - START: ser_out=0 for one cycle, then go to DATA with bit=0.
  - DATA: ser_out=shift[0]. Each cycle, shift right and increment bit. After bit WIDTH-1, go to STOP.
  - STOP: ser_out=1 and frame_done=1 for one cycle. If fifo_count≠0, pop and go straight to START. Otherwise go to IDLE.
- ser_out, ser_busy and frame_done are registered outputs decoded from the next state. They have no combinational path from inputs.
- When full, a pop frees a slot. in_ready rises on the cycle after the pop edge, never on the same cycle.

## Timing
- Reset values:
  - FSM: IDLE.
  - Pointers, bit counter, shift register: 0.
  - fifo_count: 0.
  - in_ready: 1.
  - ser_out: 1.
  - ser_busy: 0.
  - frame_done: 0.
- Timing of a word pushed at edge T into an empty FIFO with the FSM in IDLE:
  - fifo_count=1 after T.
  - Pop at edge T+1; start bit visible T+1..T+2.
  - Data bit i visible after edge T+2+i.
  - Stop bit and frame_done visible after edge T+2+WIDTH.
  - ser_busy is high from T+1 through the stop cycle.
- Frame length is WIDTH+2 cycles. Back-to-back frames have no idle gap between stop and start.
- Sustained throughput is one word per WIDTH+2 cycles. The FIFO absorbs bursts of up to DEPTH words.
- Read and write pointers wrap modulo DEPTH. Full/empty is judged from fifo_count only, never from pointer equality.
- Reset mid-frame:
  - ser_out goes to 1 and ser_busy to 0 asynchronously.
  - The partial frame is abandoned, with no frame_done pulse.
  - Buffered words are discarded.
- Reset released during in_valid=1: first push occurs on the first clk edge after deassertion.

## Test plan
- Single word 4'b1101 pushed at T:
  - ser_out after edges T+1..T+6 reads 0,1,0,1,1,1.
  - frame_done is high only after T+6.
  - fifo_count goes 0→1→0.
- Four words 0x0,0xF,0xA,0x5 on consecutive cycles:
  - fifo_count peaks at 3; the first word is popped while the rest arrive.
  - Frames are contiguous, 6 cycles each.
  - ser_out payloads are 0000, 1111, 0101, 1010 (LSB first).
- Five words held valid continuously (0x1..0x5) with the serializer busy:
  - fifo_count reaches 4 and in_ready drops to 0.
  - 0x5 is held, then accepted one cycle after the next pop.
  - All five are transmitted in order.
- Simultaneous push and pop at the STOP→START transition with fifo_count=2: fifo_count stays 2 and no word is lost or duplicated.
- rst asserted during DATA bit 2 of word 0x9 with 2 more words queued:
  - ser_out=1, fifo_count=0 and ser_busy=0 immediately.
  - No frame_done pulse.
  - After release, a fresh push of 0x6 produces a clean frame 0,0,1,1,0,1.
- Pointer wrap: stream 12 words 0x0..0xB with random in_valid gaps. The serialized sequence matches the input order exactly across two or more pointer wraps.

Source files
------------

// File: rtl/nand_result_serializer.sv
// Capture stage for NAND result words. Words are accepted on a valid/ready
// handshake into a small FIFO. Each word is then sent on one wire as a frame:
// a start bit (0), the data bits LSB first, and a stop bit (1).
module nand_result_serializer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     ser_out,
  output logic                     ser_busy,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_busy_q, ser_busy_d;
  logic             frame_done_q, frame_done_d;

  logic             push;
  logic             pop;

  assign in_ready   = (count_q != FULL);
  assign push       = in_valid && in_ready;
  assign fifo_count = count_q;
  assign ser_out    = ser_out_q;
  assign ser_busy   = ser_busy_q;
  assign frame_done = frame_done_q;

  // FIFO storage write; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer next-state, including the pop decision
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        bit_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        shift_d = shift_q >> 1;
        if (bit_q == LAST_BIT) begin
          state_d = S_STOP;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      S_STOP: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line outputs decoded from the next state so they register with it.
  // In DATA the bit leaving next is shift_d[0]: the unshifted word on entry
  // from START, the shifted word while staying in DATA.
  always_comb begin
    ser_out_d    = 1'b1;
    ser_busy_d   = (state_d != S_IDLE);
    frame_done_d = (state_d == S_STOP);
    unique case (state_d)
      S_START: ser_out_d = 1'b0;
      S_DATA:  ser_out_d = shift_d[0];
      default: ser_out_d = 1'b1;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= S_IDLE;
      bit_q        <= '0;
      shift_q      <= '0;
      ser_out_q    <= 1'b1;
      ser_busy_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      ser_out_q    <= ser_out_d;
      ser_busy_q   <= ser_busy_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
